// File: rtl/instr_sequencer.sv
// Cycle-state generator and instruction register for the 16-bit CPU.
// Drives one-hot FETCH/EXEC1/EXEC2 strobes, run/step control, STP halt and a retire counter.
module instr_sequencer #(
    parameter logic [15:0] NOP_WORD = 16'h7C00,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             run,
    input  logic             step,
    input  logic [15:0]      RAMi_q,
    input  logic             E2,
    output logic [15:0]      instr,
    output logic             FETCH,
    output logic             EXEC1,
    output logic             EXEC2,
    output logic             busy,
    output logic             halted,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count
);

    // state   | meaning
    // S_IDLE  | waiting for run, or a step while run=0
    // S_FETCH | instruction RAM read in flight
    // S_EXEC1 | first execute cycle, new word straight from RAM
    // S_EXEC2 | optional second execute cycle, word from IR
    // S_HALT  | STP retired; only RESET leaves
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC1 = 3'd2,
        S_EXEC2 = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] ir;
    logic        is_stp;

    assign is_stp = ~RAMi_q[15] & (RAMi_q[14:9] == 6'b111111);

    // Strobes come straight off the state register so E2 never feeds back combinationally.
    assign FETCH  = (state == S_FETCH);
    assign EXEC1  = (state == S_EXEC1);
    assign EXEC2  = (state == S_EXEC2);
    assign busy   = FETCH | EXEC1 | EXEC2;
    assign halted = (state == S_HALT);
    assign retire = (EXEC1 & (is_stp | ~E2)) | EXEC2;
    assign instr  = EXEC1 ? RAMi_q : ir;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state       <= S_IDLE;
            ir          <= NOP_WORD;
            instr_count <= '0;
        end else begin
            if (retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            if (EXEC1) begin
                ir <= RAMi_q;
            end
            case (state)
                S_IDLE: begin
                    if (run | step) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_EXEC1;
                S_EXEC1: begin
                    if (is_stp) begin
                        state <= S_HALT;
                    end else if (E2) begin
                        state <= S_EXEC2;
                    end else begin
                        state <= run ? S_FETCH : S_IDLE;
                    end
                end
                S_EXEC2: state <= run ? S_FETCH : S_IDLE;
                S_HALT:  state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: directed test-plan sequences plus random run/step/E2/RAM traffic,
// with per-cycle expectations queued by an instruction-level model and popped by a monitor.
module tb_instr_sequencer;

    logic        CLK;
    logic        RESET;
    logic        run;
    logic        step;
    logic [15:0] RAMi_q;
    logic        E2;
    logic [15:0] instr;
    logic        FETCH, EXEC1, EXEC2, busy, halted, retire;
    logic [15:0] instr_count;

    logic [15:0] w_instr;
    logic        w_fetch, w_exec1, w_exec2, w_busy, w_halted, w_retire;
    logic [3:0]  w_count;

    instr_sequencer dut (
        .CLK(CLK), .RESET(RESET), .run(run), .step(step), .RAMi_q(RAMi_q), .E2(E2),
        .instr(instr), .FETCH(FETCH), .EXEC1(EXEC1), .EXEC2(EXEC2), .busy(busy),
        .halted(halted), .retire(retire), .instr_count(instr_count)
    );

    // Narrow counter copy exercises the wrap to zero within a short run.
    instr_sequencer #(.NOP_WORD(16'h7C00), .CNT_W(4)) u_wrap (
        .CLK(CLK), .RESET(RESET), .run(run), .step(step), .RAMi_q(RAMi_q), .E2(E2),
        .instr(w_instr), .FETCH(w_fetch), .EXEC1(w_exec1), .EXEC2(w_exec2), .busy(w_busy),
        .halted(w_halted), .retire(w_retire), .instr_count(w_count)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0]  strobes;   // FETCH, EXEC1, EXEC2, busy, halted, retire
        logic [15:0] instr;
        logic [15:0] count;
        logic [3:0]  wcount;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_err = 0;

    // Instruction-level model: where we are inside the current instruction.
    // m_pos: 0 = between instructions, 1 = fetch, 2 = first exec, 3 = second exec.
    int          m_pos;
    bit          m_halt;
    logic [15:0] m_ir;
    int unsigned m_retired;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    function automatic bit stp_word(input logic [15:0] w);
        return (w[15] == 1'b0) && (w[14:9] == 6'b111111);
    endfunction

    task automatic model_cycle(input bit r, input bit s, input logic [15:0] q, input bit e);
        exp_t x;
        bit   ret;
        bit   last_exec;
        last_exec = (m_pos == 2 && (stp_word(q) || !e)) || (m_pos == 3);
        ret = !m_halt && last_exec;
        x.strobes = {(!m_halt && m_pos == 1), (!m_halt && m_pos == 2), (!m_halt && m_pos == 3),
                     (!m_halt && m_pos != 0), m_halt, ret};
        x.instr   = (!m_halt && m_pos == 2) ? q : m_ir;
        x.count   = 16'(m_retired);
        x.wcount  = 4'(m_retired);
        exp_q.push_back(x);
        if (m_halt) return;
        if (m_pos == 2) m_ir = q;
        if (ret) m_retired++;
        if (m_pos == 0) begin
            if (r || s) m_pos = 1;
        end else if (m_pos == 2 && stp_word(q)) begin
            m_halt = 1'b1;
            m_pos  = 0;
        end else if (ret) begin
            m_pos = r ? 1 : 0;
        end else begin
            m_pos = m_pos + 1;
        end
    endtask

    task automatic cyc(input bit r, input bit s, input logic [15:0] q, input bit e);
        run = r; step = s; RAMi_q = q; E2 = e;
        model_cycle(r, s, q, e);
        @(posedge CLK); #1;
    endtask

    task automatic do_reset();
        RESET = 1'b1; run = 1'b0; step = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        RESET = 1'b0;
        m_pos = 0; m_halt = 1'b0; m_ir = 16'h7C00; m_retired = 0;
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("strobes", {26'd0, FETCH, EXEC1, EXEC2, busy, halted, retire}, {26'd0, x.strobes});
            chk("instr", {16'd0, instr}, {16'd0, x.instr});
            chk("instr_count", {16'd0, instr_count}, {16'd0, x.count});
            chk("wrap_count", {28'd0, w_count}, {28'd0, x.wcount});
        end
    end

    initial begin
        int unsigned base;
        int          halt_cycles;
        bit          r, s, e;
        logic [15:0] q;
        RESET = 1'b1; run = 1'b0; step = 1'b0; RAMi_q = 16'h0000; E2 = 1'b0;
        do_reset();
        chk("reset_instr", {16'd0, instr}, 32'h7C00);
        chk("reset_count", {16'd0, instr_count}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 16'($urandom), 1'($urandom));

        // free run, two-cycle instructions
        for (int i = 0; i < 20; i++) cyc(1, 0, 16'h0123 + 16'(i), 0);
        cyc(0, 0, 16'h0456, 0);
        chk("free_run_count", {16'd0, instr_count}, 32'd10);

        // three-cycle instruction, IR holds across RAM change
        cyc(0, 1, 16'h0000, 0);
        cyc(0, 0, 16'h0000, 1);
        cyc(0, 0, 16'hA800, 1);
        cyc(0, 0, 16'h1234, 0);
        chk("exec2_ir", {16'd0, instr}, 32'hA800);
        cyc(0, 0, 16'h1234, 1);

        // single step with a second step on the retire cycle
        base = m_retired;
        cyc(0, 1, 16'h0000, 0);
        cyc(0, 0, 16'h0000, 0);
        cyc(0, 1, 16'h2222, 0);
        cyc(0, 0, 16'h3333, 0);
        cyc(0, 0, 16'h3333, 0);
        chk("step_count", {16'd0, instr_count}, 32'(base + 1));

        // STP halt, then step/run ignored until reset
        cyc(1, 0, 16'h0000, 0);
        cyc(1, 0, 16'h0000, 0);
        cyc(1, 0, 16'h7E00, 1);
        chk("halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 20; i++) cyc(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom));
        do_reset();
        chk("unhalt", {31'd0, halted}, 32'd0);

        // random traffic
        halt_cycles = 0;
        for (int i = 0; i < 900; i++) begin
            if (m_halt) halt_cycles++;
            if (halt_cycles > 12 || $urandom_range(0, 199) == 0) begin
                do_reset();
                halt_cycles = 0;
            end else begin
                r = ($urandom_range(0, 3) != 0);
                s = 1'($urandom);
                e = 1'($urandom);
                q = 16'($urandom);
                if (stp_word(q)) q[15] = 1'b1;
                if ($urandom_range(0, 80) == 0) q = 16'h7E00 | 16'($urandom_range(0, 511));
                cyc(r, s, q, e);
            end
        end
        @(negedge CLK); #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
